// File: rtl/product_accumulator_if.sv
// Handshake bundle between the upstream multiplier, the product accumulator and its consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             start;
  logic             abort;
  logic [7:0]       product;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, abort, product, in_valid, out_ready,
    input  in_ready, acc_out, overflow, out_valid, busy
  );

  modport slave (
    input  start, abort, product, in_valid, out_ready,
    output in_ready, acc_out, overflow, out_valid, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products into an ACC_W-bit register with a sticky overflow flag,
// then holds the result until the consumer takes it.
module product_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  // abort masks ready so a product offered on the abort cycle is never taken
  assign bus.in_ready = (state_q == ACCUM) && !bus.abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sum          = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.product};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.abort) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (accept) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | sum[ACC_W];
          if (cnt_q == LAST) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_product_accumulator.sv
// Directed scoreboard bench: default build (4 x 12-bit) plus a 5 x 10-bit build for overflow wrap.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(12)) bus_a ();
  product_accumulator_if #(.ACC_W(10)) bus_b ();

  product_accumulator #(.COUNT(4), .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  product_accumulator #(.COUNT(5), .ACC_W(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  typedef struct {
    logic [31:0] acc;
    logic [31:0] ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   mdl_sum = 0;
  int   mdl_n = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push_exp(input int sum, input int w);
    exp_t e;
    e.acc = 32'(sum % (1 << w));
    e.ovf = (sum >= (1 << w)) ? 32'd1 : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    mdl_sum = 0;
    mdl_n = 0;
  endtask

  task automatic send_a(input logic [7:0] p, input int gap);
    bus_a.product  = p;
    bus_a.in_valid = 1'b1;
    mdl_sum += int'(p);
    mdl_n++;
    if (mdl_n == 4) push_exp(mdl_sum, 12);
    tick();
    bus_a.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Waits (bounded) for out_valid on the selected DUT, then checks it against the scoreboard head.
  task automatic wait_result(input bit sel, input string tag);
    int n = 0;
    exp_t e;
    while (!(sel ? bus_b.out_valid : bus_a.out_valid) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(sel ? bus_b.out_valid : bus_a.out_valid), 32'd1);
    check({tag, "_sbq"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_acc"}, sel ? 32'(bus_b.acc_out) : 32'(bus_a.acc_out), e.acc);
      check({tag, "_ovf"}, 32'(sel ? bus_b.overflow : bus_a.overflow), e.ovf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.start = 0; bus_a.abort = 0; bus_a.product = 0; bus_a.in_valid = 1; bus_a.out_ready = 0;
    bus_b.start = 0; bus_b.abort = 0; bus_b.product = 0; bus_b.in_valid = 0; bus_b.out_ready = 0;
    tick();
    tick();
    // reset state, with in_valid held high to show in_ready stays low in IDLE
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_acc", 32'(bus_a.acc_out), 32'd0);
    check("rst_ovf", 32'(bus_a.overflow), 32'd0);
    check("rst_ready", 32'(bus_a.in_ready), 32'd0);
    bus_a.in_valid = 0;

    // start on the very first edge with rst_n released; four back-to-back 225s
    rst_n = 1'b1;
    start_a();
    check("t1_busy", 32'(bus_a.busy), 32'd1);
    for (int i = 0; i < 4; i++) send_a(8'd225, 0);
    check("t1_lat", 32'(bus_a.out_valid), 32'd1);
    wait_result(1'b0, "t1");
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check("t1_idle_valid", 32'(bus_a.out_valid), 32'd0);
    check("t1_idle_busy", 32'(bus_a.busy), 32'd0);

    // gapped products, result held for five cycles with in_valid asserted
    start_a();
    send_a(8'd10, 2);
    send_a(8'd0, 2);
    send_a(8'd20, 2);
    send_a(8'd30, 0);
    wait_result(1'b0, "t2");
    bus_a.in_valid = 1'b1;
    bus_a.product  = 8'd77;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_hold_ready", 32'(bus_a.in_ready), 32'd0);
      check("t2_hold_acc", 32'(bus_a.acc_out), 32'd60);
      check("t2_hold_valid", 32'(bus_a.out_valid), 32'd1);
      tick();
    end
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check("t2_release", 32'(bus_a.out_valid), 32'd0);

    // abort after two accepts drops the offered product and returns to IDLE
    start_a();
    send_a(8'd50, 0);
    send_a(8'd50, 0);
    bus_a.abort = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.product = 8'd99;
    #1;
    check("t4_abort_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    bus_a.abort = 1'b0;
    bus_a.in_valid = 1'b0;
    check("t4_abort_busy", 32'(bus_a.busy), 32'd0);
    start_a();
    for (int i = 0; i < 4; i++) send_a(8'd1, 0);
    wait_result(1'b0, "t4");
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;

    // reset mid-accumulation after acc reached 300
    start_a();
    for (int i = 0; i < 3; i++) send_a(8'd100, 0);
    check("t5_pre_acc", 32'(bus_a.acc_out), 32'd300);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_valid", 32'(bus_a.out_valid), 32'd0);
    check("t5_busy", 32'(bus_a.busy), 32'd0);
    check("t5_acc", 32'(bus_a.acc_out), 32'd0);
    start_a();
    for (int i = 0; i < 4; i++) send_a(8'd7, 0);
    wait_result(1'b0, "t5");
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;

    // start held high throughout: no restart in ACCUM/HOLD or on the handshake cycle
    bus_a.start = 1'b1;
    tick();
    mdl_sum = 0;
    mdl_n = 0;
    for (int i = 0; i < 4; i++) send_a(8'd5, 0);
    wait_result(1'b0, "t6");
    tick();
    check("t6_hold_acc", 32'(bus_a.acc_out), 32'd20);
    check("t6_hold_valid", 32'(bus_a.out_valid), 32'd1);
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check("t6_idle_busy", 32'(bus_a.busy), 32'd0);
    tick();
    check("t6_restart", 32'(bus_a.busy), 32'd1);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;

    // 5 x 10-bit build: 5 x 225 = 1125 wraps to 101 and sets overflow
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    push_exp(5 * 225, 10);
    for (int i = 0; i < 5; i++) begin
      bus_b.product = 8'd225;
      bus_b.in_valid = 1'b1;
      tick();
    end
    bus_b.in_valid = 1'b0;
    wait_result(1'b1, "t3");
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    check("t3_sticky_idle", 32'(bus_b.overflow), 32'd1);
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    check("t3_ovf_clear", 32'(bus_b.overflow), 32'd0);
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
